// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game engine: countdown, timed play, LFSR mole placement, whack scoring.
// Define WHACK_PENALTY_EN to make dark-lane whacks during play cost one point.
module whack_game_ctrl #(
  parameter int unsigned NUM_MOLES        = 16,
  parameter int unsigned BASE_TICK_CYCLES = 10_000_000,
  parameter int unsigned COUNT_START      = 3,
  parameter int unsigned GAME_SECONDS     = 30,
  parameter int unsigned SCORE_W          = 14
) (
  input  logic                 clock_i,
  input  logic                 reset_ni,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [NUM_MOLES-1:0] switches_i,
  output logic [NUM_MOLES-1:0] moles_o,
  output logic [SCORE_W-1:0]   score_o,
  output logic [3:0]           count_o,
  output logic [1:0]           state_o,
  output logic                 hit_o,
  output logic                 miss_o
);

  localparam int unsigned BASE_W    = (BASE_TICK_CYCLES > 1) ? $clog2(BASE_TICK_CYCLES) : 1;
  localparam int unsigned IDX_W     = $clog2(NUM_MOLES);
  localparam int unsigned GAME_W    = $clog2(GAME_SECONDS + 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    COUNTDOWN = 2'b01,
    PLAY      = 2'b10,
    DONE      = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_MOLES-1:0] moles_q, moles_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [3:0]           count_q, count_d;
  logic                 hit_q, hit_d, miss_q, miss_d;
  logic [1:0]           mode_q, mode_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [GAME_W-1:0]    game_q, game_d;

  logic                 start_s1, start_s2, start_q;
  logic [NUM_MOLES-1:0] sw_s1, sw_s2, sw_q;
  logic [15:0]          lfsr_q;
  logic [BASE_W-1:0]    base_cnt_q;
  logic [3:0]           sec_div_q, mole_div_q, mole_period;

  logic                 start_evt, hit, base_tick, sec_tick, mole_tick, entry, expire;
  logic [NUM_MOLES-1:0] whack, new_moles;
  logic [IDX_W-1:0]     cand_idx, new_idx;

  // Two-flop synchronisers plus an edge register on every asynchronous input
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_q  <= 1'b0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      sw_q     <= '0;
    end else begin
      start_s1 <= start_i;
      start_s2 <= start_s1;
      start_q  <= start_s2;
      sw_s1    <= switches_i;
      sw_s2    <= sw_s1;
      sw_q     <= sw_s2;
    end
  end

  assign start_evt = start_s2 & ~start_q;
  assign whack     = sw_s2 ^ sw_q;
  assign hit       = (state_q == PLAY) && (|(whack & moles_q));

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) lfsr_q <= LFSR_SEED;
    else           lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_comb begin
    case (mode_q)
      2'b10:   mole_period = 4'd2;
      2'b11:   mole_period = 4'd1;
      default: mole_period = 4'd10;
    endcase
  end

  assign base_tick = (base_cnt_q == BASE_W'(BASE_TICK_CYCLES - 1));
  assign sec_tick  = base_tick && (sec_div_q == 4'd9);
  assign mole_tick = base_tick && (mole_div_q == (mole_period - 4'd1));
  assign entry     = (state_d != state_q);
  assign expire    = sec_tick && (game_q == GAME_W'(GAME_SECONDS - 1));

  // Tick dividers restart on every state entry so phases line up with the transition
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      base_cnt_q <= '0;
      sec_div_q  <= '0;
      mole_div_q <= '0;
    end else if (entry) begin
      base_cnt_q <= '0;
      sec_div_q  <= '0;
      mole_div_q <= '0;
    end else begin
      base_cnt_q <= base_tick ? '0 : base_cnt_q + BASE_W'(1);
      if (base_tick) begin
        sec_div_q  <= (sec_div_q == 4'd9) ? 4'd0 : sec_div_q + 4'd1;
        mole_div_q <= (mole_div_q == (mole_period - 4'd1)) ? 4'd0 : mole_div_q + 4'd1;
      end
    end
  end

  // Next mole: LFSR mod lanes, bumped by one if it repeats the previous lane
  always_comb begin
    cand_idx  = IDX_W'(32'(lfsr_q) % NUM_MOLES);
    new_idx   = (cand_idx == idx_q) ? IDX_W'((32'(cand_idx) + 32'd1) % NUM_MOLES) : cand_idx;
    new_moles = NUM_MOLES'(1) << new_idx;
  end

`ifdef WHACK_PENALTY_EN
  logic dark_whack;
  assign dark_whack = |(whack & ~(NUM_MOLES'(1) << idx_q));
`endif

  always_comb begin
    state_d = state_q;
    moles_d = moles_q;
    score_d = score_q;
    count_d = count_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    mode_d  = mode_q;
    idx_d   = idx_q;
    game_d  = game_q;
    if (mode_i == 2'b00) begin
      state_d = IDLE;
      moles_d = '0;
      count_d = 4'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          moles_d = '0;
          count_d = 4'd0;
          if (start_evt) begin
            mode_d  = mode_i;
            score_d = '0;
            count_d = 4'(COUNT_START);
            state_d = COUNTDOWN;
          end
        end
        COUNTDOWN: begin
          if (sec_tick) begin
            if (count_q == 4'd1) begin
              state_d = PLAY;
              count_d = 4'd0;
              moles_d = new_moles;
              idx_d   = new_idx;
              game_d  = '0;
            end else begin
              count_d = count_q - 4'd1;
            end
          end
        end
        PLAY: begin
          if (hit) begin
            hit_d   = 1'b1;
            score_d = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);
            moles_d = '0;
          end
`ifdef WHACK_PENALTY_EN
          else if (dark_whack && (score_q != '0)) begin
            score_d = score_q - SCORE_W'(1);
          end
`endif
          if (mole_tick && (|moles_q) && !hit) miss_d = 1'b1;
          if (sec_tick && !expire) game_d = game_q + GAME_W'(1);
          if (expire) begin
            state_d = DONE;
            moles_d = '0;
          end else if (mole_tick) begin
            moles_d = new_moles;
            idx_d   = new_idx;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      moles_q <= '0;
      score_q <= '0;
      count_q <= 4'd0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      mode_q  <= 2'b00;
      idx_q   <= '0;
      game_q  <= '0;
    end else begin
      state_q <= state_d;
      moles_q <= moles_d;
      score_q <= score_d;
      count_q <= count_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      game_q  <= game_d;
    end
  end

  assign moles_o = moles_q;
  assign score_o = score_q;
  assign count_o = count_q;
  assign state_o = state_q;
  assign hit_o   = hit_q;
  assign miss_o  = miss_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Directed bench for whack_game_ctrl with short tick periods and an independent LFSR model.
module tb_whack_game_ctrl;

  localparam int unsigned NM = 16;
  localparam int unsigned SW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    mode_i = 2'b00;
  logic [NM-1:0] sw = '0;
  logic [NM-1:0] moles_o;
  logic [SW-1:0] score_o;
  logic [3:0]    count_o;
  logic [1:0]    state_o;
  logic          hit_o, miss_o;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_idx  = 0;
  int lane     = 0;
  int prev_idx = 0;
  int pen_score = 0;
  logic [15:0] m_lfsr, m_prev;

  whack_game_ctrl #(
    .NUM_MOLES(NM), .BASE_TICK_CYCLES(4), .COUNT_START(3), .GAME_SECONDS(2), .SCORE_W(SW)
  ) dut (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start_i), .mode_i(mode_i),
    .switches_i(sw), .moles_o(moles_o), .score_o(score_o), .count_o(count_o),
    .state_o(state_o), .hit_o(hit_o), .miss_o(miss_o)
  );

  always #5 clk = ~clk;

  // Reference LFSR: m_prev holds the value the DUT used on the latest edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start(input logic [1:0] m);
    mode_i  = m;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(2);
  endtask

  function automatic int pick(input logic [15:0] l, input int last);
    int c;
    c = int'(l) % NM;
    if (c == last) c = (c + 1) % NM;
    return c;
  endfunction

  function automatic logic [31:0] onehot(input int i);
    logic [31:0] v;
    v = 32'd1 << i;
    return v;
  endfunction

  task automatic expect_new_mole(input string tag);
    prev_idx = exp_idx;
    exp_idx  = pick(m_prev, prev_idx);
    check(tag, 32'(moles_o), onehot(exp_idx));
    check({tag, "_norepeat"}, 32'(exp_idx != prev_idx), 32'd1);
  endtask

  initial begin
    tick(2);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_moles", 32'(moles_o), 32'd0);
    check("rst_score", 32'(score_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_hit",   32'(hit_o),   32'd0);
    check("rst_miss",  32'(miss_o),  32'd0);
    rst_n = 1'b1;
    tick(2);

    // Game 1: easy mode, countdown timing, hit, repeat toggle, hit on expiry
    press_start(2'b01);
    check("g1_cd_state", 32'(state_o), 32'd1);
    check("g1_cd_3", 32'(count_o), 32'd3);
    tick(39);
    check("g1_cd_3_hold", 32'(count_o), 32'd3);
    tick(1);
    check("g1_cd_2", 32'(count_o), 32'd2);
    tick(40);
    check("g1_cd_1", 32'(count_o), 32'd1);
    tick(39);
    check("g1_pre_play", 32'(state_o), 32'd1);
    tick(1);
    check("g1_play", 32'(state_o), 32'd2);
    check("g1_play_count", 32'(count_o), 32'd0);
    expect_new_mole("g1_first_mole");
    sw[exp_idx] = ~sw[exp_idx];
    tick(2);
    check("g1_hit_early", 32'(hit_o), 32'd0);
    check("g1_lit_early", 32'(moles_o), onehot(exp_idx));
    tick(1);
    check("g1_hit", 32'(hit_o), 32'd1);
    check("g1_score1", 32'(score_o), 32'd1);
    check("g1_dark_after_hit", 32'(moles_o), 32'd0);
    tick(1);
    check("g1_hit_pulse_end", 32'(hit_o), 32'd0);
    sw[exp_idx] = ~sw[exp_idx];
    tick(3);
    check("g1_rehit_none", 32'(hit_o), 32'd0);
    check("g1_rehit_score", 32'(score_o), 32'd1);
    tick(33);
    check("g1_tick_nomiss", 32'(miss_o), 32'd0);
    expect_new_mole("g1_mole2");
    tick(37);
    sw[exp_idx] = ~sw[exp_idx];
    tick(3);
    check("g1_exp_hit", 32'(hit_o), 32'd1);
    check("g1_exp_score", 32'(score_o), 32'd2);
    check("g1_exp_nomiss", 32'(miss_o), 32'd0);
    check("g1_done", 32'(state_o), 32'd3);
    check("g1_done_moles", 32'(moles_o), 32'd0);

    // Game 2: hard mode from DONE, no whacks, miss per tick
    press_start(2'b11);
    check("g2_restart_state", 32'(state_o), 32'd1);
    check("g2_restart_score", 32'(score_o), 32'd0);
    check("g2_restart_count", 32'(count_o), 32'd3);
    tick(120);
    check("g2_play", 32'(state_o), 32'd2);
    expect_new_mole("g2_first_mole");
    for (int k = 1; k < 20; k++) begin
      tick(3);
      check("g2_miss_gap", 32'(miss_o), 32'd0);
      tick(1);
      check("g2_miss", 32'(miss_o), 32'd1);
      expect_new_mole("g2_mole");
    end
    tick(4);
    check("g2_last_miss", 32'(miss_o), 32'd1);
    check("g2_done", 32'(state_o), 32'd3);
    check("g2_done_moles", 32'(moles_o), 32'd0);
    check("g2_done_score", 32'(score_o), 32'd0);
    tick(1);
    check("g2_miss_end", 32'(miss_o), 32'd0);

    // Game 3: hit on a mole tick, dark-lane whacks, abort by mode 00
    press_start(2'b11);
    tick(120);
    check("g3_play", 32'(state_o), 32'd2);
    expect_new_mole("g3_first_mole");
    tick(1);
    sw[exp_idx] = ~sw[exp_idx];
    tick(3);
    check("g3_hit_tick", 32'(hit_o), 32'd1);
    check("g3_hit_tick_nomiss", 32'(miss_o), 32'd0);
    check("g3_hit_tick_score", 32'(score_o), 32'd1);
    expect_new_mole("g3_hit_tick_mole");
`ifdef WHACK_PENALTY_EN
    pen_score = 0;
`else
    pen_score = 1;
`endif
    lane = (exp_idx + 1) % NM;
    sw[lane] = ~sw[lane];
    tick(3);
    check("g3_dark_score", 32'(score_o), 32'(pen_score));
    check("g3_dark_nohit", 32'(hit_o), 32'd0);
    tick(1);
    check("g3_miss", 32'(miss_o), 32'd1);
    expect_new_mole("g3_mole3");
    lane = (exp_idx + 1) % NM;
    sw[lane] = ~sw[lane];
    tick(3);
    check("g3_dark_sat", 32'(score_o), 32'(pen_score));
    mode_i = 2'b00;
    tick(1);
    check("g3_abort_state", 32'(state_o), 32'd0);
    check("g3_abort_moles", 32'(moles_o), 32'd0);
    check("g3_abort_count", 32'(count_o), 32'd0);
    check("g3_abort_score", 32'(score_o), 32'(pen_score));
    check("g3_abort_nomiss", 32'(miss_o), 32'd0);

    // Game 4: asynchronous reset during countdown
    press_start(2'b01);
    check("g4_cd_state", 32'(state_o), 32'd1);
    tick(10);
    check("g4_cd_count", 32'(count_o), 32'd3);
    rst_n = 1'b0;
    #1;
    check("g4_rst_state", 32'(state_o), 32'd0);
    check("g4_rst_count", 32'(count_o), 32'd0);
    check("g4_rst_moles", 32'(moles_o), 32'd0);
    check("g4_rst_score", 32'(score_o), 32'd0);
    check("g4_rst_hit",   32'(hit_o),   32'd0);
    check("g4_rst_miss",  32'(miss_o),  32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("g4_post_rst_idle", 32'(state_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
